// File: rtl/gray_pkg.sv
// Shared Gray-code helpers for the Gray pointer counter, the Gray-to-binary decoder and the async FIFO.
// Functions work on GRAY_MAX_WIDTH-bit vectors; narrower users zero-extend and truncate.
package gray_pkg;

    localparam int GRAY_MAX_WIDTH = 32;

    function automatic logic [GRAY_MAX_WIDTH-1:0] bin2gray(input logic [GRAY_MAX_WIDTH-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at and above it.
    function automatic logic [GRAY_MAX_WIDTH-1:0] gray2bin(input logic [GRAY_MAX_WIDTH-1:0] gray);
        logic [GRAY_MAX_WIDTH-1:0] bin;
        bin[GRAY_MAX_WIDTH-1] = gray[GRAY_MAX_WIDTH-1];
        for (int i = GRAY_MAX_WIDTH - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/bin_to_gray.sv
// Combinational binary-to-Gray encoder of parameterised width.
module bin_to_gray #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] bin_i,
    output logic [WIDTH-1:0] gray_o
);

    assign gray_o = bin_i ^ (bin_i >> 1);

endmodule

// File: rtl/gray_ptr_counter.sv
// Binary counter with a registered Gray-code copy, used for FIFO pointers and cross-clock counts.
// Optional macro GRAY_PTR_DOWN_EN adds a `dir` input for down-counting.
module gray_ptr_counter
    import gray_pkg::*;
#(
    parameter int              WIDTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             load_en,
    input  logic [WIDTH-1:0] load_bin,
    input  logic             inc_en,
`ifdef GRAY_PTR_DOWN_EN
    input  logic             dir,
`endif
    output logic [WIDTH-1:0] bin_out,
    output logic [WIDTH-1:0] gray_out,
    output logic [WIDTH-1:0] bin_next,
    output logic [WIDTH-1:0] gray_next,
    output logic             wrap
);

    localparam logic [WIDTH-1:0] RESET_GRAY =
        WIDTH'(bin2gray(GRAY_MAX_WIDTH'(RESET_VAL)));

    logic [WIDTH-1:0] bin_q;
    logic [WIDTH-1:0] gray_q;
    logic             wrap_q;
    logic [WIDTH-1:0] bin_d;
    logic [WIDTH-1:0] gray_d;
    logic             wrap_d;
    logic             down;

`ifdef GRAY_PTR_DOWN_EN
    assign down = dir;
`else
    assign down = 1'b0;
`endif

    always_comb begin
        bin_d  = bin_q;
        wrap_d = 1'b0;
        if (clear) begin
            bin_d = RESET_VAL;
        end else if (load_en) begin
            bin_d = load_bin;
        end else if (inc_en) begin
            if (down) begin
                bin_d  = bin_q - WIDTH'(1);
                wrap_d = (bin_q == '0);
            end else begin
                bin_d  = bin_q + WIDTH'(1);
                wrap_d = &bin_q;
            end
        end
    end

    // Gray is registered from the encoded next value so the output flop changes one bit per step.
    bin_to_gray #(
        .WIDTH (WIDTH)
    ) u_bin_to_gray (
        .bin_i  (bin_d),
        .gray_o (gray_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bin_q  <= RESET_VAL;
            gray_q <= RESET_GRAY;
            wrap_q <= 1'b0;
        end else begin
            bin_q  <= bin_d;
            gray_q <= gray_d;
            wrap_q <= wrap_d;
        end
    end

    assign bin_out   = bin_q;
    assign gray_out  = gray_q;
    assign wrap      = wrap_q;
    assign bin_next  = bin_d;
    assign gray_next = gray_d;

endmodule

// File: tb/tb_gray_ptr_counter.sv
// Self-checking bench for gray_ptr_counter (WIDTH=4): directed scenarios plus random control traffic
// compared against an arithmetic reference model and the tabulated 4-bit Gray sequence.
module tb_gray_ptr_counter;

    localparam int         W  = 4;
    localparam logic [3:0] RV = 4'd0;

    logic       clk;
    logic       rst_n;
    logic       clear;
    logic       load_en;
    logic [3:0] load_bin;
    logic       inc_en;
    logic       dir;
    logic [3:0] bin_out;
    logic [3:0] gray_out;
    logic [3:0] bin_next;
    logic [3:0] gray_next;
    logic       wrap;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference state: count as a plain integer modulo 16, expected wrap pulse.
    int unsigned m_cnt;
    logic        m_wrap;
    logic [3:0]  gtab [16];

    gray_ptr_counter #(
        .WIDTH     (W),
        .RESET_VAL (RV)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .load_en   (load_en),
        .load_bin  (load_bin),
        .inc_en    (inc_en),
`ifdef GRAY_PTR_DOWN_EN
        .dir       (dir),
`endif
        .bin_out   (bin_out),
        .gray_out  (gray_out),
        .bin_next  (bin_next),
        .gray_next (gray_next),
        .wrap      (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int unsigned model_next(input int unsigned cur, input logic c, input logic l,
                                               input logic [3:0] lb, input logic i, input logic d,
                                               output logic w);
        int unsigned n;
        logic        down;
        down = 1'b0;
`ifdef GRAY_PTR_DOWN_EN
        down = d;
`endif
        w = 1'b0;
        n = cur;
        if (c)       n = int'(RV);
        else if (l)  n = int'(lb);
        else if (i) begin
            if (down) begin
                w = (cur == 0);
                n = (cur + 15) % 16;
            end else begin
                w = (cur == 15);
                n = (cur + 1) % 16;
            end
        end
        return n;
    endfunction

    // Called just after a falling edge: drive, check combinational outputs, clock, check registers.
    task automatic step(input logic c, input logic l, input logic [3:0] lb, input logic i, input logic d);
        int unsigned n;
        logic        w;
        clear = c; load_en = l; load_bin = lb; inc_en = i; dir = d;
        #1;
        n = model_next(m_cnt, c, l, lb, i, d, w);
        chk("bin_next", 32'(bin_next), 32'(n));
        chk("gray_next", 32'(gray_next), 32'(gtab[n]));
        @(posedge clk);
        m_cnt  = n;
        m_wrap = w;
        @(negedge clk);
        chk("bin_out", 32'(bin_out), 32'(m_cnt));
        chk("gray_out", 32'(gray_out), 32'(gtab[m_cnt]));
        chk("wrap", 32'(wrap), 32'(m_wrap));
        $display("step clr=%0b ld=%0b lb=%0h inc=%0b dir=%0b -> bin=%0h gray=%0h wrap=%0b",
                 c, l, lb, i, d, bin_out, gray_out, wrap);
    endtask

    initial begin
        logic [3:0] prev;
        gtab = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4,
                 4'hC, 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8};
        clear = 0; load_en = 0; load_bin = 0; inc_en = 0; dir = 0;
        rst_n = 0;
        m_cnt = int'(RV);
        m_wrap = 0;
        #2;
        chk("reset_bin", 32'(bin_out), 32'(RV));
        chk("reset_gray", 32'(gray_out), 32'(gtab[RV]));
        chk("reset_wrap", 32'(wrap), 32'(0));
        @(negedge clk);
        rst_n = 1;

        // Asynchronous reset in the middle of a count.
        repeat (5) step(0, 0, 4'h0, 1, 0);
        chk("pre_reset_bin", 32'(bin_out), 32'd5);
        inc_en = 0;
        #2 rst_n = 0;
        #1;
        chk("async_rst_bin", 32'(bin_out), 32'd0);
        chk("async_rst_gray", 32'(gray_out), 32'd0);
        chk("async_rst_wrap", 32'(wrap), 32'd0);
        m_cnt = int'(RV);
        m_wrap = 0;
        @(negedge clk);
        rst_n = 1;

        // Full sweep with one-bit-change check through the wrap.
        prev = gray_out;
        for (int k = 0; k < 20; k++) begin
            step(0, 0, 4'h0, 1, 0);
            chk("gray_onebit", 32'($countones(gray_out ^ prev)), 32'd1);
            prev = gray_out;
        end

        // Priority: clear beats load beats inc.
        step(1, 1, 4'h9, 1, 0);
        chk("prio_clear", 32'(bin_out), 32'(RV));
        step(0, 1, 4'h9, 1, 0);
        chk("prio_load_gray", 32'(gray_out), 32'hD);

        // Load at the top boundary then wrap.
        step(0, 1, 4'hF, 0, 0);
        step(0, 0, 4'h0, 1, 0);
        chk("bound_wrap", 32'(wrap), 32'd1);
        step(0, 0, 4'h0, 0, 0);
        chk("bound_wrap_end", 32'(wrap), 32'd0);
        step(0, 1, 4'hF, 1, 0);
        chk("load15_nowrap", 32'(wrap), 32'd0);

        // Hold at 6.
        step(0, 1, 4'h6, 0, 0);
        repeat (10) step(0, 0, 4'h0, 0, 0);
        chk("hold_gray", 32'(gray_out), 32'h5);

        // Random control traffic.
        for (int k = 0; k < 300; k++) begin
            step(($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0), 4'($urandom),
                 ($urandom_range(0, 3) != 0),
`ifdef GRAY_PTR_DOWN_EN
                 1'($urandom)
`else
                 1'b0
`endif
                 );
        end

`ifdef GRAY_PTR_DOWN_EN
        // Down-count from 0 through the lower wrap and back to 0.
        step(1, 0, 4'h0, 0, 0);
        step(0, 0, 4'h0, 1, 1);
        chk("down_wrap_gray", 32'(gray_out), 32'h8);
        chk("down_wrap_pulse", 32'(wrap), 32'd1);
        prev = gray_out;
        for (int k = 0; k < 15; k++) begin
            step(0, 0, 4'h0, 1, 1);
            chk("down_onebit", 32'($countones(gray_out ^ prev)), 32'd1);
            prev = gray_out;
        end
        chk("down_end_bin", 32'(bin_out), 32'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
